// File: rtl/avmm_memory_pkg.sv
// -----------------------------------------------------------------------------
// avmm_memory_pkg
// Shared definitions for the per-channel AVMM memory responder model and the
// host traffic generator that drives it.
//   DATA_WIDTH / DATA_WIDTH_IN_BYTES : one cache line of payload (16 x 32 bit)
//   CAPACITY                         : number of lines in one channel
//   tg_mode_e / tg_state_e           : traffic generator mode and FSM encodings
//   TG_WR_XOR                        : scramble word mixed into write payloads
// Optional feature macro used by the traffic generator: AVMM_TG_LATENCY_STATS_EN
// -----------------------------------------------------------------------------
package avmm_memory_pkg;

    localparam int DATA_WIDTH          = 512;
    localparam int DATA_WIDTH_IN_BYTES = DATA_WIDTH / 8;
    localparam int LINE_ADDR_WIDTH     = 46;

    // Channel size in lines; line addresses wrap modulo this value.
    localparam logic [LINE_ADDR_WIDTH-1:0] CAPACITY = 46'd1024;

    localparam logic [31:0] TG_WR_XOR = 32'hA5A5_A5A5;

    typedef enum logic [1:0] {
        TG_RD    = 2'd0,
        TG_WR    = 2'd1,
        TG_WR_RD = 2'd2
    } tg_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } tg_state_e;

    // Line payload: the page frame number replicated across the line,
    // optionally scrambled with TG_WR_XOR (the pattern the generator writes).
    function automatic logic [DATA_WIDTH-1:0] tg_line_data(input logic [31:0] pfn,
                                                           input logic        wr_pat);
        logic [31:0] word;
        if (wr_pat) begin
            word = pfn ^ TG_WR_XOR;
        end else begin
            word = pfn;
        end
        return {16{word}};
    endfunction

    // 16-bit increment that sticks at all-ones.
    function automatic logic [15:0] tg_sat_inc16(input logic [15:0] val);
        if (val == 16'hFFFF) begin
            return val;
        end else begin
            return val + 16'd1;
        end
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// -----------------------------------------------------------------------------
// fifo_v3
// Small synchronous FIFO used by the traffic generator to hold read issue
// timestamps. Only compiled when AVMM_TG_LATENCY_STATS_EN is defined.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   flush_i       : empty the FIFO
//   push_i/data_i : write side (push ignored when full)
//   pop_i/data_o  : read side, data_o shows the head entry (pop ignored when empty)
//   empty_o       : no entries stored
// -----------------------------------------------------------------------------
`ifdef AVMM_TG_LATENCY_STATS_EN
module fifo_v3 #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i,
    output logic                  empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         rd_ptr_r;
    logic [PW:0]           cnt_r;
    logic                  do_push_s;
    logic                  do_pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == LAST_IDX) begin
            return {PW{1'b0}};
        end else begin
            return p + {{(PW-1){1'b0}}, 1'b1};
        end
    endfunction

    assign do_push_s = push_i && (cnt_r != FULL_CNT);
    assign do_pop_s  = pop_i && (cnt_r != {(PW+1){1'b0}});
    assign empty_o   = (cnt_r == {(PW+1){1'b0}});
    assign data_o    = mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            cnt_r    <= {(PW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            if (do_push_s && !do_pop_s) begin
                cnt_r <= cnt_r + {{PW{1'b0}}, 1'b1};
            end else if (!do_push_s && do_pop_s) begin
                cnt_r <= cnt_r - {{PW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array (contents need no reset)
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end
endmodule
`endif

// File: rtl/avmm_host_traffic_gen.sv
// -----------------------------------------------------------------------------
// avmm_host_traffic_gen
// AVMM host that issues bursts of single-line writes and/or reads to one memory
// channel and checks in-order read data against a deterministic pattern.
//   clk, rstn                  : clock, synchronous active-low reset
//   start, mode, num_req       : launch a burst (honoured only when idle/done)
//   read, write, address,
//   byteenable, writedata      : AVMM request, combinational from state, gated by ready
//   readdata, readdatavalid    : AVMM in-order responses
//   ready                      : responder accepts a request this cycle
//   busy, done                 : burst in progress / finished
//   err_count, rsp_count       : data mismatches + unexpected responses, responses seen
//   lat_min, lat_max           : read latency extremes (AVMM_TG_LATENCY_STATS_EN only)
// Optional feature macro: AVMM_TG_LATENCY_STATS_EN
// -----------------------------------------------------------------------------
module avmm_host_traffic_gen
    import avmm_memory_pkg::*;
#(
    parameter int                         MAX_OUTSTANDING = 32,
    parameter logic [LINE_ADDR_WIDTH-1:0] BASE_LINE       = 46'd0,
    parameter logic [LINE_ADDR_WIDTH-1:0] ADDR_STRIDE     = 46'd1
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           start,
    input  logic [1:0]                     mode,
    input  logic [15:0]                    num_req,
    output logic                           read,
    output logic                           write,
    output logic [LINE_ADDR_WIDTH-1:0]     address,
    output logic [DATA_WIDTH_IN_BYTES-1:0] byteenable,
    output logic [DATA_WIDTH-1:0]          writedata,
    input  logic [DATA_WIDTH-1:0]          readdata,
    input  logic                           readdatavalid,
    input  logic                           ready,
    output logic                           busy,
    output logic                           done,
    output logic [15:0]                    err_count,
`ifdef AVMM_TG_LATENCY_STATS_EN
    output logic [15:0]                    rsp_count,
    output logic [15:0]                    lat_min,
    output logic [15:0]                    lat_max
`else
    output logic [15:0]                    rsp_count
`endif
);
    localparam logic [6:0] MAX_OUT = 7'(MAX_OUTSTANDING);

    tg_state_e                  state_r;
    tg_state_e                  state_s;
    tg_mode_e                   mode_r;
    tg_mode_e                   mode_s;
    logic [15:0]                num_req_r;
    logic [15:0]                req_cnt_r;
    logic [LINE_ADDR_WIDTH-1:0] addr_r;
    logic [LINE_ADDR_WIDTH-1:0] rsp_line_r;
    logic [6:0]                 outstanding_r;
    logic [15:0]                err_count_r;
    logic [15:0]                rsp_count_r;
    logic                       start_ok_s;
    logic                       last_req_s;
    logic                       wr_fire_s;
    logic                       rd_fire_s;
    logic                       rsp_ok_s;
    logic [DATA_WIDTH-1:0]      exp_data_s;

    // Next line index; both inputs are below CAPACITY so one subtract suffices.
    function automatic logic [LINE_ADDR_WIDTH-1:0] next_line(input logic [LINE_ADDR_WIDTH-1:0] cur);
        logic [LINE_ADDR_WIDTH:0] sum;
        sum = {1'b0, cur} + {1'b0, ADDR_STRIDE};
        if (sum >= {1'b0, CAPACITY}) begin
            sum = sum - {1'b0, CAPACITY};
        end else begin
            sum = sum;
        end
        return sum[LINE_ADDR_WIDTH-1:0];
    endfunction

    assign start_ok_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign last_req_s = (req_cnt_r == (num_req_r - 16'd1));
    assign wr_fire_s  = (state_r == ST_WRITE) && ready;
    assign rd_fire_s  = (state_r == ST_READ) && ready && (outstanding_r < MAX_OUT);
    // A response only retires a read when one is actually pending.
    assign rsp_ok_s   = readdatavalid && (outstanding_r != 7'd0);
    assign exp_data_s = tg_line_data(rsp_line_r[31:0], (mode_r == TG_WR_RD));

    // Decode the requested mode; the reserved encoding behaves as read-only.
    always_comb begin
        case (mode)
            2'd1:    mode_s = TG_WR;
            2'd2:    mode_s = TG_WR_RD;
            default: mode_s = TG_RD;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (!start_ok_s) begin
                    state_s = state_r;
                end else if (num_req == 16'd0) begin
                    state_s = ST_DONE;
                end else if (mode_s != TG_RD) begin
                    state_s = ST_WRITE;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_WRITE: begin
                if (wr_fire_s && last_req_s) begin
                    state_s = (mode_r == TG_WR_RD) ? ST_READ : ST_DONE;
                end else begin
                    state_s = ST_WRITE;
                end
            end
            ST_READ: begin
                if (rd_fire_s && last_req_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (outstanding_r == 7'd0) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM outputs: bus request fields are zero unless a request is accepted now
    always_comb begin
        read       = 1'b0;
        write      = 1'b0;
        address    = {LINE_ADDR_WIDTH{1'b0}};
        byteenable = {DATA_WIDTH_IN_BYTES{1'b0}};
        writedata  = {DATA_WIDTH{1'b0}};
        if (wr_fire_s) begin
            write      = 1'b1;
            address    = addr_r;
            byteenable = {DATA_WIDTH_IN_BYTES{1'b1}};
            writedata  = tg_line_data(addr_r[31:0], 1'b1);
        end else if (rd_fire_s) begin
            read    = 1'b1;
            address = addr_r;
        end else begin
            read = 1'b0;
        end
        busy = (state_r == ST_WRITE) || (state_r == ST_READ) || (state_r == ST_DRAIN);
        done = (state_r == ST_DONE);
    end

    // Burst configuration and request sequencing; the address restarts at
    // BASE_LINE when a phase completes so a following read phase replays it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mode_r    <= TG_RD;
            num_req_r <= 16'd0;
            req_cnt_r <= 16'd0;
            addr_r    <= {LINE_ADDR_WIDTH{1'b0}};
        end else if (start_ok_s) begin
            mode_r    <= mode_s;
            num_req_r <= num_req;
            req_cnt_r <= 16'd0;
            addr_r    <= BASE_LINE;
        end else if ((wr_fire_s || rd_fire_s) && last_req_s) begin
            req_cnt_r <= 16'd0;
            addr_r    <= BASE_LINE;
        end else if (wr_fire_s || rd_fire_s) begin
            req_cnt_r <= req_cnt_r + 16'd1;
            addr_r    <= next_line(addr_r);
        end
    end

    // Response checking, outstanding-read tracking and statistics counters
    always_ff @(posedge clk) begin
        if (!rstn) begin
            outstanding_r <= 7'd0;
            err_count_r   <= 16'd0;
            rsp_count_r   <= 16'd0;
            rsp_line_r    <= {LINE_ADDR_WIDTH{1'b0}};
        end else if (start_ok_s) begin
            outstanding_r <= 7'd0;
            err_count_r   <= 16'd0;
            rsp_count_r   <= 16'd0;
            rsp_line_r    <= BASE_LINE;
        end else begin
            if (readdatavalid) begin
                rsp_count_r <= rsp_count_r + 16'd1;
            end
            if (readdatavalid && (!rsp_ok_s || (readdata != exp_data_s))) begin
                err_count_r <= tg_sat_inc16(err_count_r);
            end
            if (rsp_ok_s) begin
                rsp_line_r <= next_line(rsp_line_r);
            end
            if (rd_fire_s && !rsp_ok_s) begin
                outstanding_r <= outstanding_r + 7'd1;
            end else if (!rd_fire_s && rsp_ok_s) begin
                outstanding_r <= outstanding_r - 7'd1;
            end
        end
    end

    assign err_count = err_count_r;
    assign rsp_count = rsp_count_r;

`ifdef AVMM_TG_LATENCY_STATS_EN
    logic [15:0] now_r;
    logic [15:0] ts_head_s;
    logic [15:0] lat_s;
    logic [15:0] lat_min_r;
    logic [15:0] lat_max_r;
    logic        ts_empty_s;
    logic        ts_pop_s;

    assign ts_pop_s = rsp_ok_s && !ts_empty_s;
    assign lat_s    = now_r - ts_head_s;

    fifo_v3 #(
        .DATA_WIDTH (16),
        .DEPTH      (MAX_OUTSTANDING)
    ) u_ts_fifo (
        .clk_i   (clk),
        .rst_ni  (rstn),
        .flush_i (start_ok_s),
        .data_i  (now_r),
        .push_i  (rd_fire_s),
        .data_o  (ts_head_s),
        .pop_i   (ts_pop_s),
        .empty_o (ts_empty_s)
    );

    // Free-running timestamp and min/max latency tracking
    always_ff @(posedge clk) begin
        if (!rstn) begin
            now_r     <= 16'd0;
            lat_min_r <= 16'hFFFF;
            lat_max_r <= 16'd0;
        end else begin
            now_r <= now_r + 16'd1;
            if (start_ok_s) begin
                lat_min_r <= 16'hFFFF;
                lat_max_r <= 16'd0;
            end else if (ts_pop_s) begin
                if (lat_s < lat_min_r) begin
                    lat_min_r <= lat_s;
                end
                if (lat_s > lat_max_r) begin
                    lat_max_r <= lat_s;
                end
            end
        end
    end

    assign lat_min = lat_min_r;
    assign lat_max = lat_max_r;
`endif

endmodule

// File: doc/avmm_host_traffic_gen.md
Name: avmm_host_traffic_gen

Overview:
- AVMM host (initiator) that drives the channel AVMM memory responder model.
- Issues programmable bursts of single-line reads and/or writes under `ready` and outstanding-read flow control.
- Checks in-order read responses against a deterministic expected pattern and reports error and response counts.
- One instance per memory channel in simulation benches.

Parameters:
- MAX_OUTSTANDING, 32: maximum reads issued but not yet answered; 1..64.
- BASE_LINE, 0: first line index (address[51:6]) of every burst.
- ADDR_STRIDE, 1: line-index increment between consecutive requests.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- start  in  1  pulse; launches a burst when idle or done
- mode  in  2  0=read-only, 1=write-only, 2=write-then-read, 3=reserved (treated as 0)
- num_req  in  16  requests per phase; sampled on accepted start
- read  out  1  AVMM read request
- write  out  1  AVMM write request
- address  out  46  [51:6] line address
- byteenable  out  DATA_WIDTH_IN_BYTES  always all-ones when write=1, else 0
- writedata  out  DATA_WIDTH  write payload
- readdata  in  DATA_WIDTH  response data
- readdatavalid  in  1  response strobe
- ready  in  1  responder can accept a request this cycle
- busy  out  1  burst in progress
- done  out  1  burst finished; held until next start
- err_count  out  16  mismatches plus unexpected responses; saturates at 16'hFFFF
- rsp_count  out  16  read responses received this burst

Behaviour:
- Clock clk; reset rstn, synchronous, active-low.
- Reset puts the FSM in IDLE and clears everything. All outputs are 0: read, write, address, byteenable, writedata, busy, done, err_count, rsp_count, outstanding.
- Reset mid-burst aborts immediately with no drain.
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
- start is honoured only in IDLE or DONE; ignored while busy.
  - On an honoured start: latch mode and num_req, clear counters and done.
  - Next state: WRITE for mode 1 or 2, READ for mode 0 or 3.
  - num_req=0 goes straight to DONE with no bus activity.
- Issue rule: at most one request per cycle, driven combinationally from registered state.
  - read or write is asserted only in a cycle where ready=1; that assertion counts as accepted that same cycle.
  - Reads additionally require outstanding < MAX_OUTSTANDING.
  - read and write are never both high.
- Address of request i (0-based within a phase): (BASE_LINE + i*ADDR_STRIDE) mod CAPACITY.
  - Computed incrementally with one conditional subtract.
  - Wraps at CAPACITY.
- Write payload: {16{pfn ^ 32'hA5A5_A5A5}}, where pfn = address[37:6].
- WRITE state: after the num_req-th accepted write, go to READ if mode=2, else DONE.
  - No wait is needed; the responder preserves order.
- READ state: after the num_req-th accepted read, go to DRAIN.
- DRAIN state: go to DONE when outstanding=0.
- DONE state: busy=0, done=1.
- Outstanding counter:
  - +1 on an accepted read; -1 on readdatavalid; simultaneous events leave it unchanged.
  - readdatavalid with outstanding=0 increments err_count; the counter stays 0.
- Response checking: responses arrive in issue order.
  - The response index j regenerates address j using the same address rule.
  - Expected data is {16{pfn}} for mode 0/3 and the write pattern for mode 2.
  - Mismatch → err_count+1 (saturating). rsp_count increments on every readdatavalid.
- busy=1 in WRITE, READ and DRAIN.

Optional Feature:
- Macro: AVMM_TG_LATENCY_STATS_EN.
- Enabled: adds outputs lat_min[15:0] (reset 16'hFFFF) and lat_max[15:0] (reset 0).
  - A 16-bit free-running cycle counter is pushed into a MAX_OUTSTANDING-deep timestamp FIFO on each accepted read.
  - The FIFO is popped on each readdatavalid.
  - latency = now − popped timestamp; updates min/max.
  - Both are cleared on an honoured start.
- Disabled: no FIFO, no counter, no lat_* ports.

Decomposition:
- avmm_memory_pkg supplies DATA_WIDTH, DATA_WIDTH_IN_BYTES and CAPACITY.
- Add to avmm_memory_pkg:
  - tg_mode_e enum (TG_RD, TG_WR, TG_WR_RD).
  - tg_state_e enum.
  - TG_WR_XOR constant (32'hA5A5_A5A5).
- Sub-module: timestamp FIFO, instantiated as existing fifo_v3 (DATA_WIDTH 16, DEPTH MAX_OUTSTANDING), only under the macro.
- Address generator is an internal function, not a module.

Test Plan:
- Mode 0, num_req=4, BASE_LINE=0, responder LATENCY=100, ready=1 → 4 reads on consecutive cycles to lines 0..3; readdata {16{32'h0}}..{16{32'h3}}; err_count=0, rsp_count=4; done about 104 cycles after start.
- Mode 2, num_req=8, BASE_LINE=CAPACITY-4 → writes to lines CAPACITY-4..CAPACITY-1, 0..3 (wrap), then 8 reads; all match the XOR pattern; err_count=0.
- MAX_OUTSTANDING=4, num_req=16, mode 0 → outstanding never exceeds 4; read stalls until responses return; rsp_count=16.
- Force ready=0 for 20 cycles mid-burst → no read/write asserted during the stall; the sequence resumes at the correct next address.
- Bench flips readdata bit 0 on response 2, then injects a spurious readdatavalid after DONE → err_count=2.
- Reset asserted in READ with 10 outstanding → next cycle all outputs 0, FSM in IDLE.
- With AVMM_TG_LATENCY_STATS_EN, LATENCY=100, uncontended mode 0 → lat_min=lat_max=100.
